exmem_burst: RTL and testbench

Parametrised Wishbone-side user-area memory: a fixed-latency BRAM access pipeline with an aligned-line prefetch buffer. Read misses fill one aligned line critical-word-first; read hits return in the same cycle; writes go through to BRAM and keep the buffer coherent. Sits in the user project area behind the Wishbone slave decode, and supersedes the fixed 10T/8-word memory.

---
 rtl/exmem_pkg.sv | 46 ++++
 rtl/exmem_bram.sv | 28 ++
 rtl/exmem_burst.sv | 239 +++++++++++++++++++++++
 tb/tb_exmem_burst.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exmem_pkg.sv
// Shared types, pipeline-entry layout and address helpers for the
// exmem_burst user-area memory (FSM states, default base, byte merge).
package exmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Pipeline entry layout; the word address occupies the top AW bits.
    localparam int PE_VALID    = 0;
    localparam int PE_WE       = 1;
    localparam int PE_SEL_LSB  = 2;
    localparam int PE_DATA_LSB = 6;
    localparam int PE_ADDR_LSB = 38;

    localparam logic [31:0] EXMEM_ADDR_BASE = 32'h3800_0000;

    function automatic logic [31:0] word_idx(input logic [31:0] adr,
                                             input logic [31:0] base);
        return (adr - base) >> 2;
    endfunction

    function automatic logic [31:0] line_tag(input logic [31:0] idx,
                                             input int ob);
        return idx >> ob;
    endfunction

    function automatic logic [31:0] line_off(input logic [31:0] idx,
                                             input int ob);
        return idx & ((32'd1 << ob) - 32'd1);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/exmem_bram.sv
// Single-port 2^AW x 32 block RAM, registered read, byte write enables.
// Ports: clk, en, we[3:0], addr, wdata in; rdata out (one cycle after en).
module exmem_bram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/exmem_burst.sv
// Wishbone user-area memory: fixed-latency BRAM pipeline plus a one-line
// prefetch buffer filled critical-word-first, kept coherent on writes.
// Ports: wb_clk_i/wb_rst_i (sync, active-high), wb_valid, wbs_we_i,
// wbs_sel_i, wbs_dat_i, wbs_adr_i in; wbs_ack_o, wbs_dat_o, pf_hit_o out.
module exmem_burst
    import exmem_pkg::*;
#(
    parameter int          LATENCY   = 10,
    parameter int          BURST     = 8,
    parameter int          AW        = 12,
    parameter logic [31:0] ADDR_BASE = EXMEM_ADDR_BASE
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_valid,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        pf_hit_o
);

    localparam int OB    = $clog2(BURST);
    localparam int TW    = AW - OB;
    localparam int NS    = LATENCY - 1;
    localparam int PW    = PE_ADDR_LSB + AW;
    localparam int LASTI = BURST - 1;
    localparam logic [OB:0] BURST_C = BURST[OB:0];
    localparam logic [OB:0] LAST_C  = LASTI[OB:0];

    // Request address decode
    logic [31:0]   idx_full;
    logic [31:0]   tag_full;
    logic [31:0]   off_full;
    logic [AW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [OB-1:0] req_off;
    logic          unused_ok;

    assign idx_full  = word_idx(wbs_adr_i, ADDR_BASE);
    assign req_idx   = idx_full[AW-1:0];
    assign tag_full  = line_tag(32'(req_idx), OB);
    assign off_full  = line_off(32'(req_idx), OB);
    assign req_tag   = tag_full[TW-1:0];
    assign req_off   = off_full[OB-1:0];
    assign unused_ok = ^{idx_full[31:AW], tag_full[31:TW], off_full[31:OB]};

    // State
    state_e        state_q, state_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [BURST-1:0] vld_q, vld_d;
    logic [31:0]   buf_q [BURST];
    logic [31:0]   buf_d [BURST];
    logic [OB-1:0] base_q, base_d;
    logic [OB:0]   iss_q, iss_d;
    logic [OB:0]   ret_q, ret_d;
    logic [PW-1:0] pipe_q [NS];
    logic [PW-1:0] pipe_d [NS];
    logic [PW-1:0] rsp_q, rsp_d;

    // Pipeline tail and BRAM stage decode
    logic [PW-1:0] last;
    logic          last_vld;
    logic [AW-1:0] last_addr;
    logic          rsp_vld;
    logic          rsp_we;
    logic [3:0]    rsp_sel;
    logic [31:0]   rsp_dat;
    logic [AW-1:0] rsp_addr;
    logic [TW-1:0] rsp_tag;
    logic [OB-1:0] rsp_off;

    assign last      = pipe_q[NS-1];
    assign last_vld  = last[PE_VALID];
    assign last_addr = last[PE_ADDR_LSB +: AW];
    assign rsp_vld   = rsp_q[PE_VALID];
    assign rsp_we    = rsp_q[PE_WE];
    assign rsp_sel   = rsp_q[PE_SEL_LSB +: 4];
    assign rsp_dat   = rsp_q[PE_DATA_LSB +: 32];
    assign rsp_addr  = rsp_q[PE_ADDR_LSB +: AW];
    assign rsp_tag   = rsp_addr[AW-1:OB];
    assign rsp_off   = rsp_addr[OB-1:0];

    // BRAM: reads are addressed from the last delay stage so data lands
    // alongside the entry in rsp_q; writes are applied from rsp_q itself.
    logic          bram_wr;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_rdata;

    assign bram_wr   = rsp_vld & rsp_we;
    assign bram_en   = last_vld | bram_wr;
    assign bram_we   = bram_wr ? rsp_sel : 4'b0000;
    assign bram_addr = bram_wr ? rsp_addr : last_addr;

    exmem_bram #(
        .AW(AW)
    ) u_bram (
        .clk  (wb_clk_i),
        .en   (bram_en),
        .we   (bram_we),
        .addr (bram_addr),
        .wdata(rsp_dat),
        .rdata(bram_rdata)
    );

    // Handshake terms
    logic beat_rd;
    logic first_beat;
    logic hit;
    logic hit_en;
    logic ack_hit;
    logic ack_miss;
    logic ack_wr;
    logic accept;

    assign beat_rd    = rsp_vld & ~rsp_we & (state_q == FILL);
    assign first_beat = beat_rd & (ret_q == '0);
    assign hit        = wb_valid & ~wbs_we_i & (tag_q == req_tag)
                      & vld_q[req_off];
    // During a fill the buffer only serves new requests once the
    // requesting access has been answered by beat 0.
    assign hit_en     = (state_q == IDLE)
                      | ((state_q == FILL) & (ret_q != '0));
    assign ack_hit    = hit & hit_en;
    assign ack_miss   = first_beat & wb_valid;
    assign ack_wr     = bram_wr & wb_valid & (state_q == WRITE);
    assign accept     = (state_q == IDLE) & wb_valid & ~hit;

    // Next state, issue and buffer update
    logic [PW-1:0] iss_ent;
    logic [OB-1:0] iss_off;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        vld_d   = vld_q;
        buf_d   = buf_q;
        base_d  = base_q;
        iss_d   = iss_q;
        ret_d   = ret_q;
        iss_ent = '0;
        iss_off = base_q + iss_q[OB-1:0];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    iss_ent[PE_VALID]            = 1'b1;
                    iss_ent[PE_WE]               = wbs_we_i;
                    iss_ent[PE_SEL_LSB +: 4]     = wbs_sel_i;
                    iss_ent[PE_DATA_LSB +: 32]   = wbs_dat_i;
                    iss_ent[PE_ADDR_LSB +: AW]   = req_idx;
                    if (wbs_we_i) begin
                        state_d = WRITE;
                    end else begin
                        state_d  = FILL;
                        tag_d    = req_tag;
                        vld_d    = '0;
                        base_d   = req_off;
                        iss_d    = '0;
                        iss_d[0] = 1'b1;
                        ret_d    = '0;
                    end
                end
            end
            FILL: begin
                // Remaining beats wrap around the line from the critical word.
                if (iss_q < BURST_C) begin
                    iss_ent[PE_VALID]          = 1'b1;
                    iss_ent[PE_ADDR_LSB +: AW] = {tag_q, iss_off};
                    iss_d                      = iss_q + 1'b1;
                end
                if (beat_rd) begin
                    buf_d[rsp_off] = bram_rdata;
                    vld_d[rsp_off] = 1'b1;
                    ret_d          = ret_q + 1'b1;
                    if (ret_q == LAST_C) state_d = IDLE;
                end
            end
            WRITE: begin
                if (bram_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bram_wr && (tag_q == rsp_tag) && vld_q[rsp_off]) begin
            buf_d[rsp_off] = merge_bytes(buf_q[rsp_off], rsp_dat, rsp_sel);
        end
    end

    // Delay line
    always_comb begin
        pipe_d[0] = iss_ent;
        for (int i = 1; i < NS; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        rsp_d = last;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            tag_q   <= '0;
            vld_q   <= '0;
            base_q  <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
            rsp_q   <= '0;
            for (int i = 0; i < NS; i++) pipe_q[i] <= '0;
            for (int i = 0; i < BURST; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            vld_q   <= vld_d;
            base_q  <= base_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
            rsp_q   <= rsp_d;
            pipe_q  <= pipe_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs
    assign wbs_ack_o = ~wb_rst_i & (ack_hit | ack_miss | ack_wr);
    assign pf_hit_o  = ~wb_rst_i & ack_hit;

    always_comb begin
        wbs_dat_o = '0;
        if (!wb_rst_i) begin
            if (ack_hit)       wbs_dat_o = buf_q[req_off];
            else if (ack_miss) wbs_dat_o = bram_rdata;
        end
    end

endmodule

// File: tb/tb_exmem_burst.sv
// Directed bench for exmem_burst: default build (10/8) and a 4/4 build.
// Inputs are shared except wb_valid, which is private to each instance.
module tb_exmem_burst;

    logic        clk;
    logic        rst;
    logic        v0;
    logic        v1;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] adr_i;
    logic        ack0, ack1;
    logic [31:0] dat0, dat1;
    logic        hit0, hit1;
    logic        cur_id;
    logic        ack_s;
    logic [31:0] dat_s;
    logic        hit_s;
    int          n_vec;
    int          n_bad;

    exmem_burst u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_valid (v0),
        .wbs_we_i (we_i),
        .wbs_sel_i(sel_i),
        .wbs_dat_i(dat_i),
        .wbs_adr_i(adr_i),
        .wbs_ack_o(ack0),
        .wbs_dat_o(dat0),
        .pf_hit_o (hit0)
    );

    exmem_burst #(
        .LATENCY(4),
        .BURST  (4)
    ) u_dut1 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_valid (v1),
        .wbs_we_i (we_i),
        .wbs_sel_i(sel_i),
        .wbs_dat_i(dat_i),
        .wbs_adr_i(adr_i),
        .wbs_ack_o(ack1),
        .wbs_dat_o(dat1),
        .pf_hit_o (hit1)
    );

    assign ack_s = cur_id ? ack1 : ack0;
    assign dat_s = cur_id ? dat1 : dat0;
    assign hit_s = cur_id ? hit1 : hit0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wv(input int i);
        logic [31:0] ii;
        ii = 32'(i);
        return 32'hC000_0000 | (ii << 16) | ii;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic id, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat,
                          output logic [31:0] rd, output logic hit);
        @(negedge clk);
        cur_id = id;
        we_i   = we;
        adr_i  = adr;
        dat_i  = dat;
        sel_i  = sel;
        if (id) v1 = 1'b1;
        else    v0 = 1'b1;
        #1;
        lat = 0;
        while (!ack_s && lat < 60) begin
            @(negedge clk);
            #1;
            lat++;
        end
        rd  = dat_s;
        hit = hit_s;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic rd_chk(input logic id, input logic [31:0] adr,
                          input int elat, input logic [31:0] edat,
                          input logic ehit, input string tag);
        int          lat;
        logic [31:0] rd;
        logic        hit;
        access(id, 1'b0, adr, 32'h0, 4'h0, lat, rd, hit);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_dat"}, rd, edat);
        chk({tag, "_hit"}, {31'b0, hit}, {31'b0, ehit});
    endtask

    task automatic wr_chk(input logic id, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input int elat, input string tag);
        int          lat;
        logic [31:0] rd;
        logic        hit;
        access(id, 1'b1, adr, dat, sel, lat, rd, hit);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_dat0"}, rd, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic seen;
        n_vec  = 0;
        n_bad  = 0;
        cur_id = 1'b0;
        rst    = 1'b1;
        v0     = 1'b0;
        v1     = 1'b0;
        we_i   = 1'b0;
        sel_i  = 4'h0;
        dat_i  = 32'h0;
        adr_i  = 32'h3800_0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", {31'b0, ack0}, 32'h0);
        chk("rst_dat0", dat0, 32'h0);
        chk("rst_hit0", {31'b0, hit0}, 32'h0);
        chk("rst_ack1", {31'b0, ack1}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Preload BRAM of the default build
        for (int i = 0; i < 9; i++) begin
            wr_chk(1'b0, 32'h3800_0000 + 32'(4 * i), wv(i), 4'hF, 10, "pre");
        end
        wr_chk(1'b0, 32'h3800_0100, wv(64), 4'hF, 10, "pre64");
        wr_chk(1'b0, 32'h3800_0104, wv(65), 4'hF, 10, "pre65");

        // Write then read the same word: both take the full latency
        wr_chk(1'b0, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 10, "wr10");
        rd_chk(1'b0, 32'h3800_0010, 10, 32'hDEAD_BEEF, 1'b0, "rd10");
        idle(8);

        // Other line; word 1 of it becomes valid one cycle after beat 1
        rd_chk(1'b0, 32'h3800_0100, 10, wv(64), 1'b0, "rd100");
        rd_chk(1'b0, 32'h3800_0104, 1, wv(65), 1'b1, "fillhit");
        idle(8);

        // Critical-word-first miss, then hit at T+18 and back-to-back hits
        rd_chk(1'b0, 32'h3800_0014, 10, wv(5), 1'b0, "rd14");
        idle(7);
        rd_chk(1'b0, 32'h3800_0000, 0, wv(0), 1'b1, "hit00");
        rd_chk(1'b0, 32'h3800_0004, 0, wv(1), 1'b1, "hit04");
        rd_chk(1'b0, 32'h3800_001C, 0, wv(7), 1'b1, "hit1c");
        rd_chk(1'b0, 32'h3800_0010, 0, 32'hDEAD_BEEF, 1'b1, "hit10");

        // Byte-masked writes keep the buffer coherent
        wr_chk(1'b0, 32'h3800_0008, 32'h0000_00AA, 4'h1, 10, "wr08");
        rd_chk(1'b0, 32'h3800_0008, 0, 32'hC002_00AA, 1'b1, "mrg08");
        wr_chk(1'b0, 32'h3800_000C, 32'h1234_5678, 4'h6, 10, "wr0c");
        rd_chk(1'b0, 32'h3800_000C, 0, 32'hC034_5603, 1'b1, "mrg0c");

        // Reset five cycles into a miss
        @(negedge clk);
        cur_id = 1'b0;
        we_i   = 1'b0;
        adr_i  = 32'h3800_0020;
        v0     = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstm_ack", {31'b0, ack0}, 32'h0);
        chk("rstm_dat", dat0, 32'h0);
        chk("rstm_hit", {31'b0, hit0}, 32'h0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        v0   = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ack0) seen = 1'b1;
        end
        chk("rstm_noack", {31'b0, seen}, 32'h0);
        rd_chk(1'b0, 32'h3800_0020, 10, wv(8), 1'b0, "rerd20");
        idle(8);

        // Out-of-range address wraps onto word 0
        rd_chk(1'b0, 32'h3800_4000, 10, wv(0), 1'b0, "alias");
        idle(8);

        // Short build: LATENCY=4, BURST=4
        wr_chk(1'b1, 32'h3800_0010, 32'hCAFE_0004, 4'hF, 4, "s_wr10");
        rd_chk(1'b1, 32'h3800_0010, 4, 32'hCAFE_0004, 1'b0, "s_rd10");
        idle(5);
        wr_chk(1'b1, 32'h3800_0024, 32'hCAFE_0009, 4'hF, 4, "s_wr24");
        wr_chk(1'b1, 32'h3800_0020, 32'hCAFE_0008, 4'hF, 4, "s_wr20");
        rd_chk(1'b1, 32'h3800_0024, 4, 32'hCAFE_0009, 1'b0, "s_rd24");
        idle(3);
        // Accepted at T+8 with full write latency: FSM is back in IDLE
        wr_chk(1'b1, 32'h3800_0028, 32'hCAFE_000A, 4'hF, 4, "s_wr28");
        rd_chk(1'b1, 32'h3800_0028, 0, 32'hCAFE_000A, 1'b1, "s_hit28");
        rd_chk(1'b1, 32'h3800_0020, 0, 32'hCAFE_0008, 1'b1, "s_hit20");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
